// File: rtl/input_debounce_pkg.sv
// Shared state encoding and widths for the input_debounce block.
package input_debounce_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_QUAL_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_QUAL_LO   = 2'd3
    } state_e;

    localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/input_debounce.sv
// Debouncer for an already-synchronized input: a level is accepted after DEBOUNCE_CYCLES consecutive samples.
// Optional saturating glitch counter enabled by the macro INPUT_DEBOUNCE_GLITCH_CNT_EN.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 16,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_count
`endif
);

    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > ((64'(1) << CNT_WIDTH) - 1)) begin : g_bad_cycles
        $error("input_debounce: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
    end

    localparam bit                   ONE_CYCLE = (DEBOUNCE_CYCLES == 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam state_e               RST_STATE = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            dout_q  <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_STABLE_LO: begin
                if (din) begin
                    if (ONE_CYCLE) begin
                        state_d = ST_STABLE_HI;
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = ST_QUAL_HI;
                        cnt_d   = CNT_WIDTH'(1);
                    end
                end
            end
            ST_QUAL_HI: begin
                if (!din) begin
                    state_d = ST_STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE_HI;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_STABLE_HI: begin
                if (!din) begin
                    if (ONE_CYCLE) begin
                        state_d = ST_STABLE_LO;
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = ST_QUAL_LO;
                        cnt_d   = CNT_WIDTH'(1);
                    end
                end
            end
            ST_QUAL_LO: begin
                if (din) begin
                    state_d = ST_STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE_LO;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_QUAL_HI) || (state_d == ST_QUAL_LO);
    end

    assign dout       = dout_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_CNT_W-1:0] glitch_q;
    logic                    abort;

    // An abort is a qualification that the input gave up before it completed.
    assign abort = ((state_q == ST_QUAL_HI) && !din) || ((state_q == ST_QUAL_LO) && din);

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_q <= '0;
        end else if (abort && (glitch_q != '1)) begin
            glitch_q <= glitch_q + GLITCH_CNT_W'(1);
        end
    end

    assign glitch_count = glitch_q;
`endif

endmodule
